regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning data width of every register and port.
REQ-002 SHALL provide parameter NREGS, default 16, meaning number of architectural registers, addressed by 4 bits.
REQ-003 SHALL provide parameter CNTW, default 2, meaning width of each per-register pending-write counter.
REQ-004 SHALL have ports:
  clk  input  1  single clock; all state updates on rising edge.
  rst  input  1  asynchronous, active-high reset.
  wbEnable  input  1  write-back strobe from the WB stage.
  wbAddr  input  4  write-back destination register (15 = return address).
  wbData  input  XLEN  write-back data.
  rdAddr1  input  4  read port 1 address (OF stage).
  rdAddr2  input  4  read port 2 address (OF stage).
  rdData1  output  XLEN  read port 1 data.
  rdData2  output  XLEN  read port 2 data.
  claimEn  input  1  OF stage issues an instruction that will write claimAddr.
  claimAddr  input  4  destination being claimed.
  busy1  output  1  rdAddr1 has an outstanding write.
  busy2  output  1  rdAddr2 has an outstanding write.
  sbErr  output  1  sticky scoreboard error flag.
  errClr  input  1  synchronous clear of sbErr.

Function
REQ-005 SHALL write wbData into register wbAddr on the rising edge when wbEnable=1; no write when wbEnable=0.
REQ-006 SHALL drive rdDataN combinationally from register rdAddrN, with write-through: if wbEnable=1 and wbAddr=rdAddrN, rdDataN = wbData in the same cycle.
REQ-007 SHALL keep one CNTW-bit pending counter per register, count[r] = number of claimed, not yet written-back writes to r.
REQ-008 SHALL on each edge update count[r] by +1 if claimEn and claimAddr=r, -1 if wbEnable and wbAddr=r, net 0 when both hit r in the same cycle.
REQ-009 SHALL saturate at 2^CNTW-1 on claim-without-WB; such a claim sets sbErr and leaves count unchanged.
REQ-010 SHALL, on WB to r with count[r]=0 and no same-cycle claim to r, perform the data write, keep count 0 and set sbErr.
REQ-011 SHALL drive busyN = (count[rdAddrN] != 0), except busyN = 0 when wbEnable=1, wbAddr=rdAddrN and count[rdAddrN]=1 (last pending write bypassed via REQ-006).
REQ-012 SHALL not let the current-cycle claim affect busy1/busy2 (claim takes effect from the next cycle).
REQ-013 SHALL hold sbErr until errClr=1; errClr and a new error in the same cycle leave sbErr=1.
REQ-014 SHALL treat all 16 registers identically; register 0 is writable (no hardwired zero).

Reset
REQ-015 SHALL on rst=1, asynchronously: all registers = 0, all counters = 0, sbErr = 0; consequently rdData1/2 = 0 and busy1/2 = 0 unless write-through applies.
REQ-016 SHALL ignore wbEnable and claimEn while rst=1; first update occurs on the first rising edge after rst deasserts.

Structure
REQ-017 SHALL place XLEN, NREGS, register-address width (4) and the return-address index (15) in the shared pipeline package used by the OF and WB stages.
REQ-018 SHALL implement the counter array as one sub-module, sb_counter_bank, holding counters, busy lookup and sbErr; storage array and read muxes stay in the top.

Verification
REQ-019 Reset then read: rst pulse, rdAddr1=3, rdAddr2=15 -> rdData1=0, rdData2=0, busy1=busy2=0, sbErr=0.
REQ-020 Write-through: wbEnable=1, wbAddr=5, wbData=0xDEADBEEF, rdAddr1=5 same cycle -> rdData1=0xDEADBEEF before the edge; after the edge with wbEnable=0 -> still 0xDEADBEEF.
REQ-021 Claim/release: claimEn on r7 cycle 0 -> busy1(rdAddr1=7) = 0 in cycle 0, 1 in cycle 1; WB to r7 in cycle 3 -> busy1=0 in cycle 3 (bypass) and cycle 4.
REQ-022 Simultaneous: count[r2]=1, claimEn r2 and wbEnable r2 same cycle -> count[r2] stays 1, busy2(rdAddr2=2)=1 next cycle, sbErr=0.
REQ-023 Saturation: 4 consecutive claims on r9 with no WB -> count 3, sbErr=1 after fourth edge; errClr=1 -> sbErr=0 next cycle; 3 WBs to r9 -> busy=0.
REQ-024 Reset mid-operation: count[r4]=2 and r4=0x55, assert rst asynchronously between edges -> busy and rdData drop to 0 immediately, no write on the following edge while rst held.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared pipeline constants used by the OF and WB stages and the register file.
package regfile_scoreboard_pkg;

  localparam int PIPE_XLEN  = 32;
  localparam int PIPE_NREGS = 16;
  localparam int REG_AW     = 4;
  localparam logic [REG_AW-1:0] RA_IDX = 4'd15;

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register pending-write counters, busy lookup and sticky error flag.
module sb_counter_bank
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREGS = PIPE_NREGS,
  parameter int CNTW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              claimEn,
  input  logic [REG_AW-1:0] claimAddr,
  input  logic              wbEnable,
  input  logic [REG_AW-1:0] wbAddr,
  input  logic [REG_AW-1:0] rdAddr1,
  input  logic [REG_AW-1:0] rdAddr2,
  input  logic              errClr,
  output logic              busy1,
  output logic              busy2,
  output logic              sbErr
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [CNTW-1:0] cnt_q [NREGS];
  logic [CNTW-1:0] cnt_d [NREGS];
  logic            err_q;
  logic            err_d;
  logic            err_hit;

  always_comb begin
    err_hit = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      // A claim and a write-back to the same register cancel out, even at zero.
      if (claimEn && claimAddr == REG_AW'(r) && !(wbEnable && wbAddr == REG_AW'(r))) begin
        if (cnt_q[r] == CNT_MAX) err_hit = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (wbEnable && wbAddr == REG_AW'(r) && !(claimEn && claimAddr == REG_AW'(r))) begin
        if (cnt_q[r] == '0) err_hit = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
    err_d = err_hit | (err_q & ~errClr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  // The last outstanding write is satisfied by the same-cycle write-through.
  always_comb begin
    busy1 = (cnt_q[rdAddr1] != '0) &&
            !(wbEnable && wbAddr == rdAddr1 && cnt_q[rdAddr1] == CNT_ONE);
    busy2 = (cnt_q[rdAddr2] != '0) &&
            !(wbEnable && wbAddr == rdAddr2 && cnt_q[rdAddr2] == CNT_ONE);
  end

  assign sbErr = err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-through and a pending-write scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = PIPE_XLEN,
  parameter int NREGS = PIPE_NREGS,
  parameter int CNTW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbEnable,
  input  logic [REG_AW-1:0] wbAddr,
  input  logic [XLEN-1:0]   wbData,
  input  logic [REG_AW-1:0] rdAddr1,
  input  logic [REG_AW-1:0] rdAddr2,
  output logic [XLEN-1:0]   rdData1,
  output logic [XLEN-1:0]   rdData2,
  input  logic              claimEn,
  input  logic [REG_AW-1:0] claimAddr,
  output logic              busy1,
  output logic              busy2,
  output logic              sbErr,
  input  logic              errClr
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (wbEnable) begin
      regs_q[wbAddr] <= wbData;
    end
  end

  always_comb begin
    rdData1 = (wbEnable && wbAddr == rdAddr1) ? wbData : regs_q[rdAddr1];
    rdData2 = (wbEnable && wbAddr == rdAddr2) ? wbData : regs_q[rdAddr2];
  end

  sb_counter_bank #(
    .NREGS (NREGS),
    .CNTW  (CNTW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .claimEn   (claimEn),
    .claimAddr (claimAddr),
    .wbEnable  (wbEnable),
    .wbAddr    (wbAddr),
    .rdAddr1   (rdAddr1),
    .rdAddr2   (rdAddr2),
    .errClr    (errClr),
    .busy1     (busy1),
    .busy2     (busy2),
    .sbErr     (sbErr)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: write-through, claim/release, saturation, reset.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbEnable;
  logic [3:0]  wbAddr;
  logic [31:0] wbData;
  logic [3:0]  rdAddr1;
  logic [3:0]  rdAddr2;
  logic [31:0] rdData1;
  logic [31:0] rdData2;
  logic        claimEn;
  logic [3:0]  claimAddr;
  logic        busy1;
  logic        busy2;
  logic        sbErr;
  logic        errClr;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .wbEnable  (wbEnable),
    .wbAddr    (wbAddr),
    .wbData    (wbData),
    .rdAddr1   (rdAddr1),
    .rdAddr2   (rdAddr2),
    .rdData1   (rdData1),
    .rdData2   (rdData2),
    .claimEn   (claimEn),
    .claimAddr (claimAddr),
    .busy1     (busy1),
    .busy2     (busy2),
    .sbErr     (sbErr),
    .errClr    (errClr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    wbEnable = 1'b0; claimEn = 1'b0; errClr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    wbAddr = '0; wbData = '0; claimAddr = '0;
    rdAddr1 = 4'd3; rdAddr2 = 4'd15;
    tick(); tick();
    chk("rst_rd1", rdData1, 32'h0);
    chk("rst_rd2", rdData2, 32'h0);
    chk("rst_busy1", {31'b0, busy1}, 32'h0);
    chk("rst_busy2", {31'b0, busy2}, 32'h0);
    chk("rst_err", {31'b0, sbErr}, 32'h0);
    rst = 1'b0;
    tick();

    // Write-through to an unclaimed register: data lands, error flags.
    rdAddr1 = 4'd5; wbEnable = 1'b1; wbAddr = 4'd5; wbData = 32'hDEADBEEF;
    #1 chk("wt_same_cycle", rdData1, 32'hDEADBEEF);
    chk("wt_other_port", rdData2, 32'h0);
    tick(); idle();
    #1 chk("wt_after_edge", rdData1, 32'hDEADBEEF);
    chk("wb_unclaimed_err", {31'b0, sbErr}, 32'h1);
    errClr = 1'b1;
    tick(); idle();
    chk("errclr", {31'b0, sbErr}, 32'h0);

    // Claim r7, release it three cycles later with bypass.
    rdAddr1 = 4'd7; claimEn = 1'b1; claimAddr = 4'd7;
    #1 chk("claim_c0_busy", {31'b0, busy1}, 32'h0);
    tick(); idle();
    #1 chk("claim_c1_busy", {31'b0, busy1}, 32'h1);
    tick();
    chk("claim_c2_busy", {31'b0, busy1}, 32'h1);
    tick();
    wbEnable = 1'b1; wbAddr = 4'd7; wbData = 32'h0000_1234;
    #1 chk("wb_c3_bypass", {31'b0, busy1}, 32'h0);
    chk("wb_c3_data", rdData1, 32'h0000_1234);
    tick(); idle();
    #1 chk("wb_c4_busy", {31'b0, busy1}, 32'h0);
    chk("wb_c4_err", {31'b0, sbErr}, 32'h0);

    // Simultaneous claim and write-back on r2 with count 1.
    rdAddr2 = 4'd2; claimEn = 1'b1; claimAddr = 4'd2;
    tick(); idle();
    claimEn = 1'b1; claimAddr = 4'd2;
    wbEnable = 1'b1; wbAddr = 4'd2; wbData = 32'hA5A5_A5A5;
    #1 chk("sim_bypass_busy2", {31'b0, busy2}, 32'h0);
    chk("sim_rd2", rdData2, 32'hA5A5_A5A5);
    tick(); idle();
    #1 chk("sim_busy2_next", {31'b0, busy2}, 32'h1);
    chk("sim_err", {31'b0, sbErr}, 32'h0);
    wbEnable = 1'b1; wbAddr = 4'd2; wbData = 32'h0BAD_F00D;
    tick(); idle();
    #1 chk("sim_drain_busy2", {31'b0, busy2}, 32'h0);
    chk("sim_drain_rd2", rdData2, 32'h0BAD_F00D);

    // Saturation on r9.
    rdAddr1 = 4'd9;
    claimEn = 1'b1; claimAddr = 4'd9;
    tick(); tick(); tick();
    chk("sat_3_err", {31'b0, sbErr}, 32'h0);
    chk("sat_3_busy", {31'b0, busy1}, 32'h1);
    tick(); idle();
    #1 chk("sat_4_err", {31'b0, sbErr}, 32'h1);
    errClr = 1'b1;
    tick(); idle();
    chk("sat_clr", {31'b0, sbErr}, 32'h0);
    errClr = 1'b1; claimEn = 1'b1; claimAddr = 4'd9;
    tick(); idle();
    #1 chk("clr_vs_new_err", {31'b0, sbErr}, 32'h1);
    errClr = 1'b1;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      wbEnable = 1'b1; wbAddr = 4'd9; wbData = 32'h900 + 32'(i);
      #1 chk($sformatf("sat_wb%0d_busy", i), {31'b0, busy1}, (i == 2) ? 32'h0 : 32'h1);
      tick(); idle();
    end
    #1 chk("sat_drained_busy", {31'b0, busy1}, 32'h0);
    chk("sat_drained_err", {31'b0, sbErr}, 32'h0);
    chk("sat_drained_rd", rdData1, 32'h902);

    // Register 0 is an ordinary register, read through port 2.
    claimEn = 1'b1; claimAddr = 4'd0;
    tick(); idle();
    wbEnable = 1'b1; wbAddr = 4'd0; wbData = 32'hCAFE_F00D; rdAddr2 = 4'd0;
    tick(); idle();
    #1 chk("r0_data", rdData2, 32'hCAFE_F00D);
    chk("r0_busy", {31'b0, busy2}, 32'h0);
    chk("r0_err", {31'b0, sbErr}, 32'h0);

    // Asynchronous reset in the middle of a busy register.
    claimEn = 1'b1; claimAddr = 4'd4;
    tick(); tick(); tick(); idle();
    wbEnable = 1'b1; wbAddr = 4'd4; wbData = 32'h55;
    tick(); idle();
    rdAddr1 = 4'd4;
    #1 chk("pre_rst_busy", {31'b0, busy1}, 32'h1);
    chk("pre_rst_data", rdData1, 32'h55);
    #1 rst = 1'b1;
    #1 chk("arst_busy", {31'b0, busy1}, 32'h0);
    chk("arst_data", rdData1, 32'h0);
    wbEnable = 1'b1; wbAddr = 4'd4; wbData = 32'h77; claimEn = 1'b1; claimAddr = 4'd4;
    tick(); idle();
    #1 chk("rst_held_nowrite", rdData1, 32'h0);
    chk("rst_held_busy", {31'b0, busy1}, 32'h0);
    chk("rst_held_err", {31'b0, sbErr}, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_data", rdData1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
